noc_flit_injector: RTL

//   Router-side injection stage directly downstream of the master unit's NoC output (nocdata/m_is_head/m_is_tail).

---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_flit_injector_if.sv | 37 +++
 rtl/noc_sync_flit_fifo.sv | 47 ++++
 rtl/noc_flit_injector.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and width helpers for the NoC flit injection path.
package noc_pkg;

   localparam int FLIT_DATA_W = 128;

   // Flit as stored in the injection FIFO; data is the opaque DATA_WIDTH+1 bus.
   typedef struct packed {
      logic                 head;
      logic                 tail;
      logic [FLIT_DATA_W:0] data;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE,
      ALLOC,
      SEND
   } inj_state_t;

   function automatic int vc_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cred_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/noc_flit_injector_if.sv
// Flit bus between the master unit, the injector and the local router input port.
interface noc_flit_injector_if #(
   parameter int DATA_WIDTH     = noc_pkg::FLIT_DATA_W,
   parameter int VIRTUAL_CH_NUM = 8
) ();

   localparam int VC_W = noc_pkg::vc_w(VIRTUAL_CH_NUM);

   logic [DATA_WIDTH:0]     in_data;
   logic                    in_head;
   logic                    in_tail;
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_WIDTH:0]     out_data;
   logic                    out_head;
   logic                    out_tail;
   logic [VC_W-1:0]         out_vc;
   logic                    out_valid;
   logic [VIRTUAL_CH_NUM-1:0] credit_in;
   logic                    busy;
   logic                    err_orphan;
   logic                    err_credit_ovf;

   // Environment side: flit source plus router credit return.
   modport master (
      output in_data, in_head, in_tail, in_valid, credit_in,
      input  in_ready, out_data, out_head, out_tail, out_vc, out_valid,
             busy, err_orphan, err_credit_ovf
   );

   modport slave (
      input  in_data, in_head, in_tail, in_valid, credit_in,
      output in_ready, out_data, out_head, out_tail, out_vc, out_valid,
             busy, err_orphan, err_credit_ovf
   );

endinterface

// File: rtl/noc_sync_flit_fifo.sv
// Single-clock flit FIFO with first-word-fall-through front; DEPTH must be a power of 2.
module noc_sync_flit_fifo #(
   parameter int WIDTH = 131,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] front,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is left unreset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign front = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/noc_flit_injector.sv
// Router-side injection stage: buffers flits, allocates one VC per packet round-robin, credit flow control.
module noc_flit_injector
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH     = FLIT_DATA_W,
   parameter int VIRTUAL_CH_NUM = 8,
   parameter int BUFFER_DEPTH   = 8,
   parameter int IN_FIFO_DEPTH  = 4
) (
   input  logic               noc_clk,
   input  logic               noc_rst,
   noc_flit_injector_if.slave bus
);

   localparam int VC_W   = vc_w(VIRTUAL_CH_NUM);
   localparam int CRED_W = cred_w(BUFFER_DEPTH);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_DEPTH);
   localparam logic [VC_W-1:0]   VC_LAST  = VC_W'(VIRTUAL_CH_NUM - 1);
   localparam logic [VC_W:0]     VC_NUM   = (VC_W+1)'(VIRTUAL_CH_NUM);

   typedef struct packed {
      logic                head;
      logic                tail;
      logic [DATA_WIDTH:0] data;
   } entry_t;

   entry_t     push_entry;
   entry_t     front;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   logic       send;
   logic       orphan;

   inj_state_t      state;
   inj_state_t      state_nxt;
   logic [VC_W-1:0] cur_vc;
   logic [VC_W-1:0] cur_vc_nxt;
   logic [VC_W-1:0] rr_ptr;
   logic [VC_W-1:0] pick_vc;
   logic [VC_W-1:0] scan_vc;
   logic [VC_W:0]   scan_sum;
   logic            pick_found;

   logic [CRED_W-1:0]         cred [VIRTUAL_CH_NUM];
   logic [VIRTUAL_CH_NUM-1:0] cred_avail;
   logic [VIRTUAL_CH_NUM-1:0] cred_dec;
   logic [VIRTUAL_CH_NUM-1:0] cred_ovf;

   assign bus.in_ready = !noc_rst && !fifo_full;
   assign push         = bus.in_valid && bus.in_ready;
   assign push_entry   = '{head: bus.in_head, tail: bus.in_tail, data: bus.in_data};
   assign bus.busy     = (state != IDLE) || !fifo_empty;

   noc_sync_flit_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (IN_FIFO_DEPTH)
   ) u_fifo (
      .clk       (noc_clk),
      .rst       (noc_rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .front     (front),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Per-VC credit status; a send and a return on the same VC cancel out.
   always_comb begin
      cred_avail = '0;
      cred_dec   = '0;
      cred_ovf   = '0;
      for (int v = 0; v < VIRTUAL_CH_NUM; v++) begin
         cred_avail[v] = (cred[v] != '0);
         cred_dec[v]   = send && (cur_vc == VC_W'(v));
         cred_ovf[v]   = bus.credit_in[v] && !cred_dec[v] && (cred[v] == CRED_MAX);
      end
   end

   always_ff @(posedge noc_clk) begin
      for (int v = 0; v < VIRTUAL_CH_NUM; v++) begin
         if (noc_rst) begin
            cred[v] <= CRED_MAX;
         end else if (bus.credit_in[v] && !cred_dec[v] && !cred_ovf[v]) begin
            cred[v] <= cred[v] + 1'b1;
         end else if (cred_dec[v] && !bus.credit_in[v]) begin
            cred[v] <= cred[v] - 1'b1;
         end
      end
   end

   // Round-robin pick: first VC at or after rr_ptr (with wrap) holding a credit.
   // NOTE: combinational blocks assign defaults first with = so no latch is inferred.
   always_comb begin
      pick_found = 1'b0;
      pick_vc    = rr_ptr;
      scan_sum   = '0;
      scan_vc    = '0;
      for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
         scan_sum = {1'b0, rr_ptr} + (VC_W+1)'(i);
         if (scan_sum >= VC_NUM) scan_sum = scan_sum - VC_NUM;
         scan_vc = scan_sum[VC_W-1:0];
         if (!pick_found && cred_avail[scan_vc]) begin
            pick_found = 1'b1;
            pick_vc    = scan_vc;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cur_vc_nxt = cur_vc;
      pop        = 1'b0;
      send       = 1'b0;
      orphan     = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               if (front.head) begin
                  state_nxt = ALLOC;
               end else begin
                  pop    = 1'b1;
                  orphan = 1'b1;
               end
            end
         end
         ALLOC: begin
            if (pick_found) begin
               cur_vc_nxt = pick_vc;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            if (!fifo_empty && cred_avail[cur_vc]) begin
               pop  = 1'b1;
               send = 1'b1;
               if (front.tail) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         state  <= IDLE;
         cur_vc <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         cur_vc <= cur_vc_nxt;
         if (send && front.tail) rr_ptr <= (cur_vc == VC_LAST) ? '0 : cur_vc + 1'b1;
      end
   end

   // Registered router-facing outputs; data holds its last value across bubbles.
   always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
         bus.out_data       <= '0;
         bus.out_head       <= 1'b0;
         bus.out_tail       <= 1'b0;
         bus.out_vc         <= '0;
         bus.out_valid      <= 1'b0;
         bus.err_orphan     <= 1'b0;
         bus.err_credit_ovf <= 1'b0;
      end else begin
         bus.out_valid      <= send;
         bus.err_orphan     <= orphan;
         bus.err_credit_ovf <= |cred_ovf;
         if (send) begin
            bus.out_data <= front.data;
            bus.out_head <= front.head;
            bus.out_tail <= front.tail;
            bus.out_vc   <= cur_vc;
         end
      end
   end

endmodule
